// File: rtl/madd_mon_pkg.sv
// Shared defaults, record type and exact-model operand slicing for the madd error monitor.
package madd_mon_pkg;

  localparam int unsigned IN_W_DEF  = 6;
  localparam int unsigned OUT_W_DEF = 4;
  localparam int unsigned ET_DEF    = 8;
  localparam int unsigned CNT_W_DEF = 16;

  // Operand vector is {c, b, a}, each OPD_W bits wide.
  localparam int unsigned OPD_W = 2;
  localparam int unsigned A_LSB = 0;
  localparam int unsigned B_LSB = 2;
  localparam int unsigned C_LSB = 4;

  typedef struct packed {
    logic [IN_W_DEF-1:0]  operands;
    logic [OUT_W_DEF-1:0] err;
    logic                 viol;
  } err_rec_t;

endpackage

// File: rtl/madd_exact_ref.sv
// Combinational exact reference for the 6-in/4-out multiply-add: a*b + c.
module madd_exact_ref
  import madd_mon_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  operands,
  output logic [OUT_W-1:0] exact
);

  localparam int unsigned RES_W = 2 * OPD_W + 1;

  logic [RES_W-1:0] a_x, b_x, c_x, res;

  assign a_x   = RES_W'(operands[A_LSB +: OPD_W]);
  assign b_x   = RES_W'(operands[B_LSB +: OPD_W]);
  assign c_x   = RES_W'(operands[C_LSB +: OPD_W]);
  assign res   = a_x * b_x + c_x;
  assign exact = OUT_W'(res);

endmodule

// File: rtl/madd_err_monitor.sv
// Streaming error monitor for approximate madd circuits: 2-stage record pipeline plus
// saturating run statistics. Define ERR_HIST_EN to add per-error histogram bins.
module madd_err_monitor
  import madd_mon_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned ET    = ET_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_operands,
  input  logic [OUT_W-1:0]       s_approx,
  input  logic                   clear,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [IN_W-1:0]        m_operands,
  output logic [OUT_W-1:0]       m_err,
  output logic                   m_viol,
  output logic [OUT_W-1:0]       err_max,
  output logic [CNT_W+OUT_W-1:0] err_sum,
  output logic [CNT_W-1:0]       sample_cnt,
  output logic [CNT_W-1:0]       viol_cnt,
  output logic                   viol_flag,
  output logic [IN_W-1:0]        first_viol_ops,
  output logic                   done
`ifdef ERR_HIST_EN
  ,
  input  logic [OUT_W-1:0]       hist_sel,
  output logic [CNT_W-1:0]       hist_cnt
`endif
);

  localparam logic [OUT_W:0]   ET_V     = (OUT_W+1)'(ET);
  localparam logic [CNT_W-1:0] DONE_PRE = CNT_W'((2 ** IN_W) - 1);
  localparam int unsigned      SUM_W    = CNT_W + OUT_W;

  // Error computation on the incoming sample
  logic [OUT_W-1:0] exact;
  logic [OUT_W:0]   diff, diff_abs;
  logic [OUT_W-1:0] err_new;
  logic             viol_new;

  madd_exact_ref #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_exact (
    .operands (s_operands),
    .exact    (exact)
  );

  always_comb begin
    diff     = {1'b0, exact} - {1'b0, s_approx};
    diff_abs = diff[OUT_W] ? (~diff + (OUT_W+1)'(1)) : diff;
    err_new  = diff_abs[OUT_W-1:0];
    viol_new = diff_abs > ET_V;
  end

  // Pipeline control
  err_rec_t s1_q, s1_d, s2_q, s2_d;
  logic     v1_q, v1_d, v2_q, v2_d;
  logic     rdy_en_q;
  logic     s2_load, s1_adv, accept;

  assign s2_load = !v2_q || m_ready;
  assign s1_adv  = v1_q && s2_load;
  // rdy_en_q holds s_ready low through reset and for the first cycle after it.
  assign s_ready = rdy_en_q && (!v1_q || s1_adv);
  assign accept  = s_valid && s_ready;

  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    v2_d = v2_q;
    s2_d = s2_q;
    if (!v1_q || s1_adv) begin
      v1_d = accept;
      if (accept) begin
        s1_d.operands = s_operands;
        s1_d.err      = err_new;
        s1_d.viol     = viol_new;
      end
    end
    if (s2_load) begin
      v2_d = v1_q;
      if (v1_q) s2_d = s1_q;
    end
  end

  // Statistics
  logic [OUT_W-1:0] err_max_q, err_max_d;
  logic [SUM_W-1:0] err_sum_q, err_sum_d;
  logic [SUM_W:0]   sum_ext;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, viol_cnt_q, viol_cnt_d;
  logic             viol_flag_q, viol_flag_d, done_q, done_d;
  logic [IN_W-1:0]  first_viol_ops_q, first_viol_ops_d;

  assign sum_ext = {1'b0, err_sum_q} + (SUM_W+1)'(s1_q.err);

  always_comb begin
    err_max_d        = err_max_q;
    err_sum_d        = err_sum_q;
    sample_cnt_d     = sample_cnt_q;
    viol_cnt_d       = viol_cnt_q;
    viol_flag_d      = viol_flag_q;
    first_viol_ops_d = first_viol_ops_q;
    done_d           = 1'b0;
    if (clear) begin
      err_max_d        = '0;
      err_sum_d        = '0;
      sample_cnt_d     = '0;
      viol_cnt_d       = '0;
      viol_flag_d      = 1'b0;
      first_viol_ops_d = '0;
    end else if (s1_adv) begin
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      err_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (s1_q.err > err_max_q) err_max_d = s1_q.err;
      done_d = (sample_cnt_q == DONE_PRE);
      if (s1_q.viol) begin
        if (viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + CNT_W'(1);
        viol_flag_d = 1'b1;
        if (!viol_flag_q) first_viol_ops_d = s1_q.operands;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q         <= 1'b0;
      v1_q             <= 1'b0;
      v2_q             <= 1'b0;
      s1_q             <= '0;
      s2_q             <= '0;
      err_max_q        <= '0;
      err_sum_q        <= '0;
      sample_cnt_q     <= '0;
      viol_cnt_q       <= '0;
      viol_flag_q      <= 1'b0;
      first_viol_ops_q <= '0;
      done_q           <= 1'b0;
    end else begin
      rdy_en_q         <= 1'b1;
      v1_q             <= v1_d;
      v2_q             <= v2_d;
      s1_q             <= s1_d;
      s2_q             <= s2_d;
      err_max_q        <= err_max_d;
      err_sum_q        <= err_sum_d;
      sample_cnt_q     <= sample_cnt_d;
      viol_cnt_q       <= viol_cnt_d;
      viol_flag_q      <= viol_flag_d;
      first_viol_ops_q <= first_viol_ops_d;
      done_q           <= done_d;
    end
  end

`ifdef ERR_HIST_EN
  logic [CNT_W-1:0] hist_q [2**OUT_W];
  logic [CNT_W-1:0] hist_d [2**OUT_W];
  logic [CNT_W-1:0] hist_cnt_q, hist_cnt_d;

  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      for (int i = 0; i < 2 ** OUT_W; i++) hist_d[i] = '0;
    end else if (s1_adv && hist_q[s1_q.err] != '1) begin
      hist_d[s1_q.err] = hist_q[s1_q.err] + CNT_W'(1);
    end
    hist_cnt_d = hist_q[hist_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2 ** OUT_W; i++) hist_q[i] <= '0;
      hist_cnt_q <= '0;
    end else begin
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  assign hist_cnt = hist_cnt_q;
`endif

  assign m_valid        = v2_q;
  assign m_operands     = s2_q.operands;
  assign m_err          = s2_q.err;
  assign m_viol         = s2_q.viol;
  assign err_max        = err_max_q;
  assign err_sum        = err_sum_q;
  assign sample_cnt     = sample_cnt_q;
  assign viol_cnt       = viol_cnt_q;
  assign viol_flag      = viol_flag_q;
  assign first_viol_ops = first_viol_ops_q;
  assign done           = done_q;

endmodule

// File: tb/tb_madd_err_monitor.sv
// Directed, table-driven bench for madd_err_monitor with hand-computed expectations.
module tb_madd_err_monitor;

  localparam int unsigned IN_W  = 6;
  localparam int unsigned OUT_W = 4;
  localparam int unsigned CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   s_valid, s_ready;
  logic [IN_W-1:0]        s_operands;
  logic [OUT_W-1:0]       s_approx;
  logic                   clear;
  logic                   m_valid, m_ready;
  logic [IN_W-1:0]        m_operands;
  logic [OUT_W-1:0]       m_err;
  logic                   m_viol;
  logic [OUT_W-1:0]       err_max;
  logic [CNT_W+OUT_W-1:0] err_sum;
  logic [CNT_W-1:0]       sample_cnt, viol_cnt;
  logic                   viol_flag;
  logic [IN_W-1:0]        first_viol_ops;
  logic                   done;
`ifdef ERR_HIST_EN
  logic [OUT_W-1:0]       hist_sel = '0;
  logic [CNT_W-1:0]       hist_cnt;
`endif

  madd_err_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_operands     (s_operands),
    .s_approx       (s_approx),
    .clear          (clear),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_operands     (m_operands),
    .m_err          (m_err),
    .m_viol         (m_viol),
    .err_max        (err_max),
    .err_sum        (err_sum),
    .sample_cnt     (sample_cnt),
    .viol_cnt       (viol_cnt),
    .viol_flag      (viol_flag),
    .first_viol_ops (first_viol_ops),
    .done           (done)
`ifdef ERR_HIST_EN
    ,
    .hist_sel       (hist_sel),
    .hist_cnt       (hist_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ops;
    logic [3:0] approx;
    logic [3:0] err;
    logic       viol;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   done_total = 0;

  always @(negedge clk) if (done) done_total++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exact_of(input logic [5:0] o);
    int a, b, c;
    a = int'(o[1:0]);
    b = int'(o[3:2]);
    c = int'(o[5:4]);
    return 4'(a * b + c);
  endfunction

  // Present one sample for one edge, then idle; returns at the negedge after acceptance.
  task automatic send(input logic [5:0] ops, input logic [3:0] ap);
    s_valid    = 1'b1;
    s_operands = ops;
    s_approx   = ap;
    @(negedge clk);
    s_valid    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         exp_cnt, exp_sum, exp_max, exp_vcnt, done_base, acc, seen;
    logic       exp_flag;
    logic [5:0] exp_first;
    logic [5:0] exp_ops [2];

    // ops = {c, b, a}
    vecs[0] = '{ops: 6'b111111, approx: 4'd4,  err: 4'd8,  viol: 1'b0}; // 12 vs 4
    vecs[1] = '{ops: 6'b111111, approx: 4'd3,  err: 4'd9,  viol: 1'b1}; // 12 vs 3
    vecs[2] = '{ops: 6'b000000, approx: 4'd15, err: 4'd15, viol: 1'b1}; // 0 vs 15
    vecs[3] = '{ops: 6'b011110, approx: 4'd7,  err: 4'd0,  viol: 1'b0}; // 2*3+1
    vecs[4] = '{ops: 6'b101001, approx: 4'd12, err: 4'd8,  viol: 1'b0}; // 1*2+2 vs 12
    vecs[5] = '{ops: 6'b001011, approx: 4'd0,  err: 4'd6,  viol: 1'b0}; // 3*2+0

    rst = 1'b1; s_valid = 1'b0; s_operands = '0; s_approx = '0; clear = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_sample_cnt", 32'(sample_cnt), 0);
    chk("rst_viol_flag", 32'(viol_flag), 0);
    rst = 1'b0;
    #1 chk("s_ready_before_rise", 32'(s_ready), 0);
    @(negedge clk);
    chk("s_ready_after_rise", 32'(s_ready), 1);

    exp_cnt = 0; exp_sum = 0; exp_max = 0; exp_vcnt = 0; exp_flag = 1'b0; exp_first = '0;
    for (int i = 0; i < 6; i++) begin
      chk("vec_s_ready", 32'(s_ready), 1);
      send(vecs[i].ops, vecs[i].approx);
      @(negedge clk);
      exp_cnt++;
      exp_sum += int'(vecs[i].err);
      if (int'(vecs[i].err) > exp_max) exp_max = int'(vecs[i].err);
      if (vecs[i].viol) begin
        exp_vcnt++;
        if (!exp_flag) exp_first = vecs[i].ops;
        exp_flag = 1'b1;
      end
      chk("vec_m_valid", 32'(m_valid), 1);
      chk("vec_m_err", 32'(m_err), 32'(vecs[i].err));
      chk("vec_m_viol", 32'(m_viol), 32'(vecs[i].viol));
      chk("vec_m_operands", 32'(m_operands), 32'(vecs[i].ops));
      chk("vec_sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
      chk("vec_err_sum", 32'(err_sum), 32'(exp_sum));
      chk("vec_err_max", 32'(err_max), 32'(exp_max));
      chk("vec_viol_cnt", 32'(viol_cnt), 32'(exp_vcnt));
      chk("vec_viol_flag", 32'(viol_flag), 32'(exp_flag));
      chk("vec_first_viol_ops", 32'(first_viol_ops), 32'(exp_first));
    end

    // Exhaustive exact sweep, back-to-back
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_sample_cnt", 32'(sample_cnt), 0);
    chk("clr_err_max", 32'(err_max), 0);
    chk("clr_viol_flag", 32'(viol_flag), 0);
    done_base = done_total;
    for (int i = 0; i < 64; i++) begin
      s_valid    = 1'b1;
      s_operands = 6'(i);
      s_approx   = exact_of(6'(i));
      #1 chk("sweep_s_ready", 32'(s_ready), 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sweep_sample_cnt", 32'(sample_cnt), 64);
    chk("sweep_err_sum", 32'(err_sum), 0);
    chk("sweep_viol_cnt", 32'(viol_cnt), 0);
    chk("sweep_done_pulses", 32'(done_total - done_base), 1);

    // Backpressure: only two samples fit
    acc = 0;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid    = 1'b1;
      s_operands = 6'(10 + acc);
      s_approx   = exact_of(6'(10 + acc));
      #1;
      if (s_ready) begin
        if (acc < 2) exp_ops[acc] = s_operands;
        acc++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 2);
    chk("bp_s_ready", 32'(s_ready), 0);
    chk("bp_m_valid_held", 32'(m_valid), 1);
    m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("bp_out_valid", 32'(m_valid), 1);
      chk("bp_out_ops", 32'(m_operands), 32'(exp_ops[k]));
      @(negedge clk);
    end
    chk("bp_drained", 32'(m_valid), 0);

    // Clear on the same edge as a violating sample's statistics update
    send(6'b111111, 4'd3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("cc_m_valid", 32'(m_valid), 1);
    chk("cc_m_viol", 32'(m_viol), 1);
    chk("cc_m_err", 32'(m_err), 9);
    chk("cc_sample_cnt", 32'(sample_cnt), 0);
    chk("cc_viol_cnt", 32'(viol_cnt), 0);
    chk("cc_viol_flag", 32'(viol_flag), 0);
    chk("cc_err_sum", 32'(err_sum), 0);
    chk("cc_err_max", 32'(err_max), 0);
    chk("cc_first_viol_ops", 32'(first_viol_ops), 0);
    @(negedge clk);

    // Reset with two samples in flight
    s_valid = 1'b1; s_operands = 6'b111111; s_approx = 4'd0;
    @(negedge clk);
    s_operands = 6'b000101; s_approx = 4'd0;
    @(negedge clk);
    s_valid = 1'b0;
    chk("mid_sample_cnt", 32'(sample_cnt), 1);
    chk("mid_viol_flag", 32'(viol_flag), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_m_valid", 32'(m_valid), 0);
    chk("mr_s_ready", 32'(s_ready), 0);
    chk("mr_sample_cnt", 32'(sample_cnt), 0);
    chk("mr_err_sum", 32'(err_sum), 0);
    chk("mr_err_max", 32'(err_max), 0);
    chk("mr_viol_cnt", 32'(viol_cnt), 0);
    chk("mr_viol_flag", 32'(viol_flag), 0);
    chk("mr_first_viol_ops", 32'(first_viol_ops), 0);
    chk("mr_m_operands", 32'(m_operands), 0);
    chk("mr_m_err", 32'(m_err), 0);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    chk("mr_no_records", 32'(seen), 0);
    chk("mr_s_ready_back", 32'(s_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
